// File: rtl/lbm_pkg.sv
// Shared LBM definitions: word format, cell layout, direction indices and
// the collision sequencer state encoding.
package lbm_pkg;

  localparam int Q_W        = 16;  // Q3.13 distribution word
  localparam int CELL_WORDS = 9;   // D2Q9 distributions per cell

  localparam int DIR_NULL = 0;
  localparam int DIR_N    = 1;
  localparam int DIR_NE   = 2;
  localparam int DIR_E    = 3;
  localparam int DIR_SE   = 4;
  localparam int DIR_S    = 5;
  localparam int DIR_SW   = 6;
  localparam int DIR_W    = 7;
  localparam int DIR_NW   = 8;

  typedef logic [CELL_WORDS*Q_W-1:0] cell_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD,
    ST_RD_LAST,
    ST_LAUNCH,
    ST_WR,
    ST_NEXT,
    ST_DONE
  } seq_state_t;

  // Pick distribution word k out of a packed cell vector.
  function automatic logic [Q_W-1:0] cell_word(input cell_vec_t v, input logic [3:0] k);
    return v[int'(k)*Q_W +: Q_W];
  endfunction

endpackage

// File: rtl/lattice_cell_counter.sv
// Walks the lattice x-fastest, keeping the cell's word base address in step
// (+9 per cell) so no multiplier is needed.
module lattice_cell_counter
  import lbm_pkg::*;
#(
  parameter int LATTICE_WIDTH  = 64,
  parameter int LATTICE_HEIGHT = 32,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] base_o,
  output logic              is_boundary_o,
  output logic              is_last_o
);

  localparam int XW = $clog2(LATTICE_WIDTH);
  localparam int YW = (LATTICE_HEIGHT > 1) ? $clog2(LATTICE_HEIGHT) : 1;

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;

  // Next position: clear to origin, or step one cell with row wrap.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    base_d = base_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      base_d = '0;
    end else if (advance_i) begin
      base_d = base_q + ADDR_W'(CELL_WORDS);
      if (x_q == XW'(LATTICE_WIDTH - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(LATTICE_HEIGHT - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      base_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      base_q <= base_d;
    end
  end

  assign base_o        = base_q;
  // Zou-He columns are handled elsewhere; the collider never touches them.
  assign is_boundary_o = (x_q == XW'(0)) || (x_q == XW'(1)) ||
                         (x_q == XW'(LATTICE_WIDTH - 2)) ||
                         (x_q == XW'(LATTICE_WIDTH - 1));
  assign is_last_o     = (x_q == XW'(LATTICE_WIDTH - 1)) &&
                         (y_q == YW'(LATTICE_HEIGHT - 1));

endmodule

// File: rtl/collide_sequencer.sv
// One BGK collision sweep: per interior cell read 9 words, hand them to the
// combinational collider, write the 9 results back in place.
module collide_sequencer
  import lbm_pkg::*;
#(
  parameter int LATTICE_WIDTH  = 64,
  parameter int LATTICE_HEIGHT = 32,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       step_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [15:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [15:0]       mem_wr_data,
  output logic [143:0]      coll_f,
  output logic              coll_valid,
  input  logic [143:0]      coll_new_f,
  input  logic              coll_busy,
  input  logic              coll_newval_ready
);

  seq_state_t        state_q, state_d;
  logic [3:0]        k_q, k_d;
  cell_vec_t         f_q, f_d;
  cell_vec_t         nf_q, nf_d;
  logic [15:0]       step_q, step_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              cnt_clear, cnt_advance;
  logic [ADDR_W-1:0] cell_base;
  logic              is_boundary, is_last;
  logic              rd_req, wr_req, strobe;
  logic [ADDR_W-1:0] addr_now;

  lattice_cell_counter #(
    .LATTICE_WIDTH (LATTICE_WIDTH),
    .LATTICE_HEIGHT(LATTICE_HEIGHT),
    .ADDR_W        (ADDR_W)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (cnt_clear),
    .advance_i    (cnt_advance),
    .base_o       (cell_base),
    .is_boundary_o(is_boundary),
    .is_last_o    (is_last)
  );

  // Sweep FSM: next state, word index, captured cell data and strobes.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    f_d         = f_q;
    nf_d        = nf_q;
    step_d      = step_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    rd_req      = 1'b0;
    wr_req      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        k_d     = '0;
        state_d = is_boundary ? ST_NEXT : ST_RD;
      end
      ST_RD: begin
        rd_req = 1'b1;
        // Read data trails its strobe by one cycle, so word k-1 lands now.
        if (k_q != 4'd0) f_d[int'(k_q - 4'd1)*Q_W +: Q_W] = mem_rd_data;
        if (k_q == 4'(CELL_WORDS - 1)) state_d = ST_RD_LAST;
        else                           k_d     = k_q + 4'd1;
      end
      ST_RD_LAST: begin
        f_d[DIR_NW*Q_W +: Q_W] = mem_rd_data;
        state_d                = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (coll_newval_ready && !coll_busy) begin
          nf_d    = coll_new_f;
          k_d     = '0;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        wr_req = 1'b1;
        if (k_q == 4'(CELL_WORDS - 1)) state_d = ST_NEXT;
        else                           k_d     = k_q + 4'd1;
      end
      ST_NEXT: begin
        cnt_advance = 1'b1;
        state_d     = is_last ? ST_DONE : ST_CHECK;
      end
      ST_DONE: begin
        step_d  = step_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes drop in the reset cycle itself so an interrupted write-back
  // never lands the word being presented when reset arrives.
  assign mem_rd_en   = rd_req && !rst;
  assign mem_wr_en   = wr_req && !rst;
  assign strobe      = mem_rd_en || mem_wr_en;
  assign addr_now    = cell_base + ADDR_W'(k_q);
  assign addr_d      = strobe ? addr_now : addr_q;
  assign mem_addr    = addr_d;
  assign mem_wr_data = mem_wr_en ? cell_word(nf_q, k_q) : 16'd0;

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      f_q     <= '0;
      nf_q    <= '0;
      step_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      f_q     <= f_d;
      nf_q    <= nf_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign coll_valid = (state_q == ST_LAUNCH);
  assign coll_f     = f_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_collide_sequencer.sv
// Directed bench for collide_sequencer on a 6x2 lattice with a +1 stub collider.
module tb_collide_sequencer;

  localparam int W     = 6;
  localparam int H     = 2;
  localparam int WORDS = W * H * 9;
  localparam int NI    = 4;
  localparam int NB    = 8;
  localparam int DONE_NOSTALL = 1 + 22 * NI + 2 * NB;
  localparam int DONE_STALL   = DONE_NOSTALL + 5 * NI;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, done;
  logic [15:0]  step_count;
  logic [15:0]  mem_addr;
  logic         mem_rd_en, mem_wr_en;
  logic [15:0]  mem_rd_data;
  logic [15:0]  mem_wr_data;
  logic [143:0] coll_f, coll_new_f;
  logic         coll_valid;
  logic         coll_busy;
  logic         coll_newval_ready;

  logic [15:0]  mem [0:WORDS-1];
  logic         load = 1'b0;
  logic         stall_mode = 1'b0;
  int           stall_cnt = 0;

  int tests = 0;
  int fails = 0;
  int proto_err = 0;
  int launch_cnt = 0;

  collide_sequencer #(
    .LATTICE_WIDTH (W),
    .LATTICE_HEIGHT(H),
    .ADDR_W        (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .step_count       (step_count),
    .mem_addr         (mem_addr),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_data      (mem_rd_data),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_data      (mem_wr_data),
    .coll_f           (coll_f),
    .coll_valid       (coll_valid),
    .coll_new_f       (coll_new_f),
    .coll_busy        (coll_busy),
    .coll_newval_ready(coll_newval_ready)
  );

  always #5 clk = ~clk;

  // Lattice RAM with one-cycle read latency; load presets word a to a.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 16'(i);
    end else begin
      if (mem_wr_en) mem[7'(mem_addr)] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[7'(mem_addr)];
    end
  end

  // Stub collider: each word plus one.
  always_comb begin
    coll_new_f = '0;
    for (int k = 0; k < 9; k++) coll_new_f[k*16 +: 16] = coll_f[k*16 +: 16] + 16'd1;
  end
  assign coll_busy         = 1'b0;
  assign coll_newval_ready = !stall_mode || (stall_cnt == 5);

  always @(posedge clk) begin
    if (!coll_valid || coll_newval_ready) stall_cnt <= 0;
    else                                  stall_cnt <= stall_cnt + 1;
  end

  // Protocol monitor, sampled mid-low-phase.
  logic         prev_rd = 1'b0, prev_valid = 1'b0, prev_rst = 1'b1;
  logic [15:0]  prev_addr = '0;
  logic [143:0] prev_f = '0;
  int           rd_base = 0;
  always @(negedge clk) begin
    #2;
    if (!(rst || prev_rst)) begin
      if (mem_rd_en && mem_wr_en) begin
        proto_err++;
        $display("FAIL rd_wr_overlap: both strobes high at addr %0d", mem_addr);
      end
      if (!mem_rd_en && !mem_wr_en && mem_addr != prev_addr) begin
        proto_err++;
        $display("FAIL addr_hold: got %0d required %0d", mem_addr, prev_addr);
      end
      if (mem_rd_en && !prev_rd) rd_base = int'(mem_addr);
      if (coll_valid && prev_valid && coll_f != prev_f) begin
        proto_err++;
        $display("FAIL coll_f_stable: coll_f changed during stall");
      end
      if (coll_valid && !prev_valid) begin
        launch_cnt++;
        for (int k = 0; k < 9; k++) begin
          if (coll_f[k*16 +: 16] != mem[7'(rd_base + k)]) begin
            proto_err++;
            $display("FAIL rd_align: word %0d of cell %0d got %0h required %0h",
                     k, rd_base, coll_f[k*16 +: 16], mem[7'(rd_base + k)]);
          end
        end
      end
    end
    prev_rst   = rst;
    prev_rd    = mem_rd_en;
    prev_valid = coll_valid;
    prev_f     = coll_f;
    prev_addr  = mem_addr;
  end

  typedef struct {
    int addr;
    int exp;
  } mem_vec_t;
  mem_vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic preload();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Start a sweep with start sampled at cycle 0; report the first done cycle.
  task automatic run_sweep(input int pulse_at, output int done_cyc, output int pulses);
    done_cyc = -1;
    pulses   = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == pulse_at)     start = 1'b1;
      if (c == pulse_at + 1) start = 1'b0;
      if (done) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc + 20) break;
    end
  endtask

  function automatic int exp_word(input int a, input int inc);
    int x;
    x = (a / 9) % W;
    return (x == 2 || x == 3) ? a + inc : a;
  endfunction

  task automatic check_mem_all(input string name, input int inc);
    int bad = 0;
    for (int a = 0; a < WORDS; a++) if (int'(mem[a]) != exp_word(a, inc)) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    int dc, np, t0, waited;
    logic found;

    vecs[0]  = '{0, 0};    vecs[1]  = '{17, 17};  vecs[2]  = '{18, 19};
    vecs[3]  = '{26, 27};  vecs[4]  = '{27, 28};  vecs[5]  = '{35, 36};
    vecs[6]  = '{36, 36};  vecs[7]  = '{53, 53};  vecs[8]  = '{54, 54};
    vecs[9]  = '{71, 71};  vecs[10] = '{72, 73};  vecs[11] = '{89, 90};
    vecs[12] = '{90, 90};

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_step", step_count, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_wr_data", mem_wr_data, 0);
    check("rst_coll_f", coll_f == '0, 1);
    check("rst_coll_valid", coll_valid, 0);

    // Plain sweep
    preload();
    run_sweep(-10, dc, np);
    check("sweep_done_cycle", dc, DONE_NOSTALL);
    check("sweep_done_pulses", np, 1);
    check("sweep_step", step_count, 1);
    check("sweep_busy_after", busy, 0);
    for (int i = 0; i < 13; i++) check($sformatf("mem_vec%0d", i), mem[vecs[i].addr], vecs[i].exp);
    check_mem_all("sweep_mem_all", 1);
    check("sweep_launches", launch_cnt, NI);
    check("sweep_protocol", proto_err, 0);

    // Collider stalls 5 cycles per cell
    preload();
    stall_mode = 1'b1;
    run_sweep(-10, dc, np);
    stall_mode = 1'b0;
    check("stall_done_cycle", dc, DONE_STALL);
    check("stall_step", step_count, 2);
    check_mem_all("stall_mem_all", 1);
    check("stall_protocol", proto_err, 0);

    // Start pulsed mid-sweep is ignored
    preload();
    run_sweep(40, dc, np);
    check("restart_done_cycle", dc, DONE_NOSTALL);
    check("restart_pulses", np, 1);
    check("restart_step", step_count, 3);
    check("restart_busy_after", busy, 0);
    check("restart_protocol", proto_err, 0);

    // Reset during write-back of cell (2,0), word 4
    preload();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    waited = 0;
    while (!found && waited < 300) begin
      @(negedge clk);
      waited++;
      if (mem_wr_en && mem_addr == 16'd22) found = 1'b1;
    end
    check("rst_wr_reached", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_wr_en", mem_wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_step", step_count, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 18; a <= 21; a++) check($sformatf("midrst_upd%0d", a), mem[a], a + 1);
    for (int a = 22; a <= 26; a++) check($sformatf("midrst_keep%0d", a), mem[a], a);
    run_sweep(-10, dc, np);
    check("resume_done_cycle", dc, DONE_NOSTALL);
    check("resume_step", step_count, 1);
    check("resume_w18", mem[18], 20);
    check("resume_w22", mem[22], 23);
    check("resume_w72", mem[72], 73);
    check("resume_protocol", proto_err, 0);

    // Step counter wrap
    @(negedge clk);
    force dut.step_q = 16'hFFFF;
    @(negedge clk);
    release dut.step_q;
    @(negedge clk);
    check("wrap_preset", step_count, 16'hFFFF);
    t0 = tests;
    run_sweep(-10, dc, np);
    check("wrap_done_cycle", dc, DONE_NOSTALL);
    check("wrap_step", step_count, 16'h0000);
    check("wrap_protocol", proto_err, 0);
    if (tests == t0) $display("note: no wrap checks");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/collide_sequencer.md
# collide_sequencer

Sequences one full LBM collision sweep over the lattice through the existing combinational BGK collider. For each interior cell it reads the 9 Q3.13 distribution words from lattice memory, launches the collider, and writes the 9 post-collision words back in place. Zou-He boundary columns (x ∈ {0, 1, W-2, W-1}) are skipped. Sits between the host/step controller (start/done) and the lattice RAM plus collider.

## Interface
- `LATTICE_WIDTH`, default 64: cells per row (W); must be ≥ 5.
- `LATTICE_HEIGHT`, default 32: rows (H); must be ≥ 1.
- `ADDR_W`, default 16: word-address width; must hold W·H·9−1.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted until DONE exits.
- `done`  out  1  one-cycle pulse at sweep end.
- `step_count`  out  16  completed sweeps; wraps 0xFFFF→0.
- `mem_addr`  out  ADDR_W  word address = cell_base + k.
- `mem_rd_en`  out  1  read strobe; `mem_rd_data` is valid exactly 1 cycle later.
- `mem_rd_data`  in  16  read data.
- `mem_wr_en`  out  1  write strobe.
- `mem_wr_data`  out  16  write data.
- `coll_f`  out  144  packed f[k], with k=0..8 in order null,n,ne,e,se,s,sw,w,nw; k=0 occupies bits [15:0].
- `coll_valid`  out  1  coll_f is stable and a result is requested.
- `coll_new_f`  in  144  collider output, same packing.
- `coll_busy`, `coll_newval_ready`  in  1 each  collider status.

## Operation
- Cell order is x fastest, then y. `cell_base` = (y·W + x)·9. It is maintained incrementally (+9 per cell); no multiplier.
- FSM states:
  - IDLE: if `start`, clear x, y and `cell_base`, then go to CHECK.
  - CHECK: go to NEXT if x is a boundary column, else go to RD.
  - RD: issue reads for k = 0..8, one per cycle, `mem_addr` = base + k. Capture `mem_rd_data` into f[k−1].
  - RD_LAST: capture f[8].
  - LAUNCH: `coll_valid`=1 with coll_f held. Advance when `coll_newval_ready && !coll_busy`; register `coll_new_f` in that same cycle.
  - WR: write k = 0..8, one per cycle, with `mem_wr_data` = new_f[k].
  - NEXT: advance x, y and base. On the last cell (x=W−1, y=H−1) go to DONE, else go to CHECK.
  - DONE: pulse `done`, increment `step_count`, go to IDLE.
- `start` outside IDLE is ignored. There is no queuing.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.
- `mem_addr` holds its last value when no strobe is asserted.
- Collider outputs are used unmodified. The block performs no arithmetic on f.
- Reset mid-sweep: next state is IDLE, and all strobes are 0 in the cycle after `rst` is sampled. The partially written cell is left as is. `step_count` is cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `step_count`=0, `mem_addr`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_wr_data`=0, `coll_f`=0, `coll_valid`=0. State is IDLE.
- Interior cell with an always-ready collider takes 22 cycles: CHECK 1, RD 9, RD_LAST 1, LAUNCH 1, WR 9, NEXT 1.
- Each collider stall cycle in LAUNCH adds 1 cycle. `coll_f` and `coll_valid` are stable throughout the stall.
- Boundary cell takes 2 cycles (CHECK, NEXT).
- If `start` is sampled at cycle 0, CHECK for cell (0,0) is cycle 1 and `done` is high at cycle 1 + 22·Ni + 2·Nb + S, where:
  - Ni = interior cells,
  - Nb = boundary cells,
  - S = total collider stall cycles.
- `busy` falls in the cycle after `done`.

## Structure
- Shared package `lbm_pkg`:
  - `Q_W`=16 (Q3.13 word width),
  - `CELL_WORDS`=9,
  - direction index constants `DIR_NULL`…`DIR_NW` (0..8),
  - 144-bit `cell_vec_t`,
  - FSM state encoding.
- One sub-module: `lattice_cell_counter`. It holds x, y and `cell_base`, and provides `is_boundary` and `is_last` outputs.

## Test plan
- W=6, H=2, stub collider with new_f[k] = f[k] + 1 and ready=1, busy=0; memory preloaded with addr[15:0]; start at cycle 0 → `done` at cycle 105. Only words of cells x=2,3 (base 18..35 and 72..89) change, each to addr+1. All other words are unchanged.
- Same setup, collider holds `coll_newval_ready`=0 for 5 cycles on each cell → `done` at cycle 125. `coll_f` is stable during every stall.
- `start` pulsed again mid-sweep → ignored: a single `done` pulse, and `step_count` rises by 1 only.
- `rst` asserted during WR of cell (2,0) at k=4 → next cycle `mem_wr_en`=0 and `busy`=0. Words 18..21 are updated and words 22..26 are unchanged. A new start then completes normally.
- 0xFFFF+1 sweeps (force `step_count` to 0xFFFF, run 1 sweep) → `step_count` = 0x0000.
- Protocol monitor over all runs: read data is used exactly 1 cycle after `mem_rd_en`; `mem_rd_en` and `mem_wr_en` are never high together.
